// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Holds HI/LO; busy covers the fixed latency of MULT/DIV ops.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;
  logic [31:0]   phi, phi_n, plo, plo_n;
  logic          pwr, pwr_n;

  logic [63:0] sa, sb, smul, umul;
  logic [31:0] ua, ub, ubd, bd;
  logic [31:0] uq, ur, sq, sr, dq, dr;
  logic        bz;

  assign sa   = {{32{A[31]}}, A};
  assign sb   = {{32{B[31]}}, B};
  assign smul = sa * sb;
  assign umul = {32'd0, A} * {32'd0, B};

  // zero divisor is steered to 1 so the datapath never sees x; result is dropped
  assign bz  = (B == 32'd0);
  assign bd  = bz ? 32'd1 : B;
  assign dq  = A / bd;
  assign dr  = A % bd;

  // signed divide on magnitudes; 0x80000000 magnitude is exact when unsigned
  assign ua  = A[31] ? (32'd0 - A) : A;
  assign ub  = B[31] ? (32'd0 - B) : B;
  assign ubd = bz ? 32'd1 : ub;
  assign uq  = ua / ubd;
  assign ur  = ua % ubd;
  assign sq  = (A[31] ^ B[31]) ? (32'd0 - uq) : uq;
  assign sr  = A[31] ? (32'd0 - ur) : ur;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    phi_n   = phi;
    plo_n   = plo;
    pwr_n   = pwr;
    unique case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              {phi_n, plo_n} = smul;
              pwr_n   = 1'b1;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = BUSY;
            end
            3'd1: begin
              {phi_n, plo_n} = umul;
              pwr_n   = 1'b1;
              cnt_n   = CW'(MULT_CYCLES);
              state_n = BUSY;
            end
            3'd2: begin
              phi_n   = sr;
              plo_n   = sq;
              pwr_n   = !bz;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = BUSY;
            end
            3'd3: begin
              phi_n   = dr;
              plo_n   = dq;
              pwr_n   = !bz;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = BUSY;
            end
            3'd4:    hi_n = A;
            3'd5:    lo_n = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          if (pwr) begin
            hi_n = phi;
            lo_n = plo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      phi   <= '0;
      plo   <= '0;
      pwr   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      phi   <= phi_n;
      plo   <= plo_n;
      pwr   <= pwr_n;
    end
  end

  assign busy = (state == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
// Hand-computed HI/LO/busy expectations checked after each edge.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle request, then scramble the operands to prove they were latched
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    op    = 3'd7;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0000_0001;
  endtask

  task automatic wait_done(input string tag,
                           input int n,
                           input int poke,
                           input logic [31:0] ohi,
                           input logic [31:0] olo,
                           input logic [31:0] ehi,
                           input logic [31:0] elo);
    for (int i = 0; i < n; i++) begin
      chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
      if (i == n - 1) begin
        chk({tag, ":hi_hold"}, HI, ohi);
        chk({tag, ":lo_hold"}, LO, olo);
      end
      if (i == poke) begin
        start = 1'b1;
        op    = 3'd4;
        A     = 32'h0000_1234;
      end else if (i == poke + 1) begin
        start = 1'b0;
        op    = 3'd7;
        A     = 32'hDEAD_BEEF;
      end
      step();
    end
    start = 1'b0;
    chk({tag, ":idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ":hi"}, HI, ehi);
    chk({tag, ":lo"}, LO, elo);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd0;
    A     = 32'd5;
    B     = 32'd7;

    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst:busy", {31'd0, busy}, 32'd0);
      chk("rst:hi", HI, 32'd0);
      chk("rst:lo", LO, 32'd0);
    end
    reset = 1'b1;
    start = 1'b0;
    step();
    chk("post_rst:busy", {31'd0, busy}, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult", 5, -1, 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 5, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
              32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10, 3, 32'hFFFF_FFFE, 32'h0000_0001,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step();
    chk("div_neg:no_mthi", HI, 32'hFFFF_FFFF);

    issue(3'd5, 32'h0000_CAFE, 32'd0);
    chk("mtlo:busy", {31'd0, busy}, 32'd0);
    chk("mtlo:lo", LO, 32'h0000_CAFE);
    chk("mtlo:hi", HI, 32'hFFFF_FFFF);

    issue(3'd4, 32'h0000_5555, 32'd0);
    chk("mthi:busy", {31'd0, busy}, 32'd0);
    chk("mthi:hi", HI, 32'h0000_5555);
    chk("mthi:lo", LO, 32'h0000_CAFE);

    issue(3'd3, 32'd100, 32'd0);
    wait_done("divu_b0", 10, -1, 32'h0000_5555, 32'h0000_CAFE,
              32'h0000_5555, 32'h0000_CAFE);

    issue(3'd2, 32'd100, 32'd0);
    wait_done("div_b0", 10, -1, 32'h0000_5555, 32'h0000_CAFE,
              32'h0000_5555, 32'h0000_CAFE);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10, -1, 32'h0000_5555, 32'h0000_CAFE,
              32'h0000_0000, 32'h8000_0000);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negb", 10, -1, 32'h0000_0000, 32'h8000_0000,
              32'h0000_0001, 32'hFFFF_FFFD);

    issue(3'd3, 32'd100, 32'd7);
    wait_done("divu", 10, -1, 32'h0000_0001, 32'hFFFF_FFFD,
              32'h0000_0002, 32'h0000_000E);

    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    chk("nop6:busy", {31'd0, busy}, 32'd0);
    chk("nop6:hi", HI, 32'h0000_0002);
    chk("nop6:lo", LO, 32'h0000_000E);

    issue(3'd2, 32'd100, 32'd7);
    step();
    step();
    chk("abort:busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step();
    chk("abort:busy", {31'd0, busy}, 32'd0);
    chk("abort:hi", HI, 32'd0);
    chk("abort:lo", LO, 32'd0);
    reset = 1'b1;
    repeat (12) step();
    chk("abort:late_busy", {31'd0, busy}, 32'd0);
    chk("abort:late_hi", HI, 32'd0);
    chk("abort:late_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
